// File: rtl/mem_moc_ram_if.sv
// Request/response bundle between the multi-cycle controller (master) and the RAM (slave).
interface mem_moc_ram_if;
    logic        memEnable;
    logic        RW;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [1:0]  size;
    logic        signExt;
    logic [31:0] dataOut;
    logic        MOC;
    logic        alignErr;

    modport master (
        output memEnable, RW, address, dataIn, size, signExt,
        input  dataOut, MOC, alignErr
    );

    modport slave (
        input  memEnable, RW, address, dataIn, size, signExt,
        output dataOut, MOC, alignErr
    );
endinterface

// File: rtl/mem_moc_ram.sv
// Big-endian byte-addressable RAM with fixed wait states and a MOC handshake that
// holds until the controller drops memEnable.
module mem_moc_ram #(
    parameter int DEPTH     = 512,
    parameter int ADDR_BITS = 9,
    parameter int LATENCY   = 2
) (
    input  logic          clk,
    input  logic          Reset,
    mem_moc_ram_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [1:0]           size_q, size_d;
    logic                 rw_q, rw_d;
    logic                 sext_q, sext_d;
    logic [31:0]          dout_q, dout_d;
    logic                 moc_q, moc_d;
    logic                 aerr_q, aerr_d;

    logic [7:0]           mem [DEPTH];

    logic                 is_byte, is_half, is_word;
    logic                 misaligned;
    logic                 finish;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] a0, a1, a2, a3;
    logic [7:0]           b0, b1, b2, b3;
    logic [7:0]           wb0, wb1;
    logic [31:0]          rd_data;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^bus.address[31:ADDR_BITS];

    assign is_byte    = (size_q == 2'b00);
    assign is_half    = (size_q == 2'b01);
    assign is_word    = size_q[1];
    assign misaligned = (is_half & addr_q[0]) | (is_word & (|addr_q[1:0]));
    assign finish     = (state_q == BUSY) && (cnt_q == LAST);
    assign mem_we     = finish & rw_q & ~misaligned;

    // Offsets wrap naturally in ADDR_BITS; aligned accesses never straddle the top.
    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_BITS'(1);
    assign a2 = addr_q + ADDR_BITS'(2);
    assign a3 = addr_q + ADDR_BITS'(3);

    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    assign wb0 = is_word ? wdata_q[31:24] : (is_half ? wdata_q[15:8] : wdata_q[7:0]);
    assign wb1 = is_word ? wdata_q[23:16] : wdata_q[7:0];

    always_comb begin
        unique case (1'b1)
            is_byte: rd_data = {{24{sext_q & b0[7]}}, b0};
            is_half: rd_data = {{16{sext_q & b0[7]}}, b0, b1};
            default: rd_data = {b0, b1, b2, b3};
        endcase
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rw_d    = rw_q;
        sext_d  = sext_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        aerr_d  = aerr_q;

        unique case (state_q)
            IDLE: begin
                moc_d = 1'b0;
                if (bus.memEnable) begin
                    addr_d  = bus.address[ADDR_BITS-1:0];
                    wdata_d = bus.dataIn;
                    size_d  = bus.size;
                    rw_d    = bus.RW;
                    sext_d  = bus.signExt;
                    cnt_d   = 4'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 4'd1;
                if (finish) begin
                    moc_d   = 1'b1;
                    aerr_d  = misaligned;
                    dout_d  = misaligned ? 32'h0 : (rw_q ? dout_q : rd_data);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.memEnable) begin
                    moc_d   = 1'b0;
                    aerr_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            rw_q    <= 1'b0;
            sext_q  <= 1'b0;
            dout_q  <= 32'h0;
            moc_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            sext_q  <= sext_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            aerr_q  <= aerr_d;
        end
    end

    // NOTE: the array has no reset branch; Reset only blocks a pending write from committing.
    always_ff @(posedge clk) begin
        if (!Reset && mem_we) begin
            mem[a0] <= wb0;
            if (!is_byte) mem[a1] <= wb1;
            if (is_word) begin
                mem[a2] <= wdata_q[15:8];
                mem[a3] <= wdata_q[7:0];
            end
        end
    end

    assign bus.dataOut  = dout_q;
    assign bus.MOC      = moc_q;
    assign bus.alignErr = aerr_q;

endmodule
